af4_ipoh_gnt8: RTL and testbench
================================

Name: af4_ipoh_gnt8

Overview:
Grant-side controller for the 8-way priority vote. It drives the vote's request vector and rotating priority base, then captures the vote's winner/valid result. It issues a registered one-hot grant to the winning requester and holds it until release, timeout or request drop. It then advances priority past the released owner so service is round-robin.

Parameters:
MAXHOLD, 255, maximum cycles a grant may be held before forced release (1..2^CNTW-1)
CNTW, 8, width of hold counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
reqin  input  8  level requests from requesters, bit i = requester i
gntdone  input  1  current owner releases grant (sampled only in GRANT)
vote_req  output  8  request vector to vote (combinational from reqin, masked per Optional Feature)
vote_prior  output  3  priority base to vote (registered)
vote_win  input  3  winner index from vote
vote_winval  input  1  winner valid from vote
gnt  output  8  registered one-hot grant
gntval  output  1  registered, equals |gnt
gntid  output  3  registered index of current/last owner
timeout  output  1  registered one-cycle pulse on forced release

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, gnt=0, gntval=0, gntid=0, vote_prior=0, hold counter=0, timeout=0.
- States: IDLE, GRANT.
- IDLE, vote_winval=1 at edge N: gntid<=vote_win, gnt<=onehot(vote_win), gntval<=1, counter<=0, state<=GRANT. Latency from reqin to gnt is 1 cycle.
- IDLE, vote_winval=0: stay in IDLE; outputs hold 0 except gntid and vote_prior.
- GRANT, release condition: gntdone=1, or reqin[gntid]=0 (implicit release), or counter==MAXHOLD-1 (timeout).
  - On release at edge N: gnt<=0, gntval<=0, state<=IDLE, vote_prior<=gntid+1 mod 8 (7 wraps to 0).
  - Timeout pulse: timeout<=1 for one cycle, only when release is due to counter expiry and neither gntdone nor request drop is true in that cycle.
- GRANT, no release: counter increments, saturating at MAXHOLD-1.
- Grant gap: minimum one cycle with gntval=0 between grants. Next grant earliest at N+2. The same requester may win again only if no other request is active after priority rotation.
- gnt, gntid and vote_prior never change during GRANT. vote_win/vote_winval are ignored in GRANT.
- Simultaneous gntdone and timeout in the same cycle: treated as normal done, no timeout pulse.
- rst asserted mid-GRANT: grant drops on the next edge, priority returns to 0.
- Invariant: gnt is always zero or exactly one-hot, and gntval==|gnt.

Optional Feature:
- Macro AF4_IPOH_GNT8_MASK_EN.
- Defined: adds input reqmsk[7:0]; vote_req = reqin & ~reqmsk. If reqmsk[gntid]=1 during GRANT, this is a release condition identical to request drop (no timeout pulse).
- Undefined: reqmsk port absent; vote_req = reqin.

Decomposition:
- Package af4_ipoh_gnt8_pkg: state encoding constants (IDLE=1'b0, GRANT=1'b1), requester count 8, index width 3.
- Sub-module af4_ipoh_dec8: 3-to-8 one-hot decoder with enable, used for gnt.
- The vote instance stays outside this block; the bench connects the real 8-way vote between vote_req/vote_prior and vote_win/vote_winval.

Test Plan:
- Reset then reqin=8'h00 for 10 cycles -> gnt=0, gntval=0, vote_prior=0, timeout never 1.
- reqin=8'h24 constant, gntdone pulsed 2 cycles after each grant -> grants alternate gntid=2, 5, 2, 5; vote_prior follows 3, 6, 3, 6; 1-cycle gap each time.
- reqin=8'h80, no gntdone, MAXHOLD=4 -> gnt=8'h80 held 4 cycles, then timeout pulse with gnt=0, vote_prior=0 (wrap from 7).
- reqin=8'h01 granted, then reqin[0] dropped -> gnt=0 next cycle, no timeout, vote_prior=1.
- rst asserted during GRANT with gntid=6 -> next cycle gnt=0, gntid=0, vote_prior=0, state IDLE.
- (MASK_EN) reqin=8'h03, reqmsk=8'h01 -> only gntid=1 granted; setting reqmsk=8'h02 mid-grant -> release next cycle, then gntid=0 granted.

Source files
------------

// File: rtl/af4_ipoh_gnt8_pkg.sv
// Shared constants and state encoding for the af4_ipoh_gnt8 grant controller.
package af4_ipoh_gnt8_pkg;

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDXW = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/af4_ipoh_dec8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module af4_ipoh_dec8
  import af4_ipoh_gnt8_pkg::*;
(
  input  logic            en,
  input  logic [IDXW-1:0] idx,
  output logic [NREQ-1:0] onehot_c
);

  assign onehot_c = en ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/af4_ipoh_gnt8.sv
// Grant-side controller for the 8-way priority vote: registered one-hot grant with round-robin rotation.
// Optional request masking is enabled by defining AF4_IPOH_GNT8_MASK_EN.
module af4_ipoh_gnt8
  import af4_ipoh_gnt8_pkg::*;
#(
  parameter int unsigned MAXHOLD = 255,
  parameter int unsigned CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] reqin,
`ifdef AF4_IPOH_GNT8_MASK_EN
  input  logic [NREQ-1:0] reqmsk,
`endif
  input  logic            gntdone,
  output logic [NREQ-1:0] vote_req,
  output logic [IDXW-1:0] vote_prior,
  input  logic [IDXW-1:0] vote_win,
  input  logic            vote_winval,
  output logic [NREQ-1:0] gnt,
  output logic            gntval,
  output logic [IDXW-1:0] gntid,
  output logic            timeout
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAXHOLD - 1);

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [IDXW-1:0] gntid_nxt, prior_nxt;
  logic            gntval_nxt, timeout_nxt;
  logic [NREQ-1:0] gnt_nxt_c;
  logic            own_req_c, expire_c, release_c;

  // Masked requests feed the vote and also decide implicit release.
`ifdef AF4_IPOH_GNT8_MASK_EN
  assign vote_req = reqin & ~reqmsk;
`else
  assign vote_req = reqin;
`endif

  assign own_req_c = vote_req[gntid];
  assign expire_c  = (cnt == CNT_LAST);
  assign release_c = gntdone || !own_req_c || expire_c;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gntid_nxt   = gntid;
    prior_nxt   = vote_prior;
    gntval_nxt  = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (vote_winval) begin
          state_nxt  = ST_GRANT;
          gntid_nxt  = vote_win;
          gntval_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          state_nxt   = ST_IDLE;
          prior_nxt   = gntid + IDXW'(1);
          timeout_nxt = expire_c && !gntdone && own_req_c;
        end else begin
          gntval_nxt = 1'b1;
          if (!expire_c) cnt_nxt = cnt + CNTW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  af4_ipoh_dec8 u_dec (
    .en       (gntval_nxt),
    .idx      (gntid_nxt),
    .onehot_c (gnt_nxt_c)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      gntid      <= '0;
      vote_prior <= '0;
      gnt        <= '0;
      gntval     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      gntid      <= gntid_nxt;
      vote_prior <= prior_nxt;
      gnt        <= gnt_nxt_c;
      gntval     <= gntval_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_af4_ipoh_gnt8.sv
// Self-checking bench for af4_ipoh_gnt8 with a behavioural rotating-priority vote and reference model.
module tb_af4_ipoh_gnt8;

  localparam int unsigned MAXHOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reqin;
  logic [7:0] reqmsk;
  logic       gntdone;
  logic [7:0] vote_req;
  logic [2:0] vote_prior;
  logic [2:0] vote_win;
  logic       vote_winval;
  logic [7:0] gnt;
  logic       gntval;
  logic [2:0] gntid;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int  m_owner = -1;
  int  m_held  = 0;
  int  m_id    = 0;
  int  m_prior = 0;
  bit  m_to    = 1'b0;
  bit  m_init  = 1'b0;

  always #5 clk = ~clk;

  af4_ipoh_gnt8 #(.MAXHOLD(MAXHOLD), .CNTW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .reqin       (reqin),
`ifdef AF4_IPOH_GNT8_MASK_EN
    .reqmsk      (reqmsk),
`endif
    .gntdone     (gntdone),
    .vote_req    (vote_req),
    .vote_prior  (vote_prior),
    .vote_win    (vote_win),
    .vote_winval (vote_winval),
    .gnt         (gnt),
    .gntval      (gntval),
    .gntid       (gntid),
    .timeout     (timeout)
  );

  // Stand-in for the external 8-way vote: first active request at or after the priority base.
  bit vfound;
  int vidx;
  always_comb begin
    vote_win    = '0;
    vote_winval = |vote_req;
    vfound      = 1'b0;
    vidx        = 0;
    for (int k = 0; k < 8; k++) begin
      vidx = (int'(vote_prior) + k) % 8;
      if (!vfound && vote_req[vidx]) begin
        vote_win = 3'(vidx);
        vfound   = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int base);
    for (int k = 0; k < 8; k++)
      if (r[(base + k) % 8]) return (base + k) % 8;
    return -1;
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, check outputs.
  task automatic step(input logic r, input logic [7:0] q, input logic d, input logic [7:0] m);
    logic [7:0] mreq;
    rst = r; reqin = q; gntdone = d; reqmsk = m;
    mreq = q & ~m;
    #1;
    chk("vote_req", 32'(vote_req), 32'(mreq));
    if (m_init) chk("vote_prior_pre", 32'(vote_prior), 32'(m_prior));
    @(posedge clk);
    if (r) begin
      m_owner = -1; m_held = 0; m_id = 0; m_prior = 0; m_to = 1'b0; m_init = 1'b1;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (mreq != 8'h00) begin
        m_owner = pick(mreq, m_prior);
        m_id    = m_owner;
        m_held  = 0;
      end
    end else begin
      bit drop, expire;
      drop   = !mreq[m_owner];
      expire = (m_held + 1 >= MAXHOLD);
      if (d || drop || expire) begin
        m_to    = expire && !d && !drop;
        m_prior = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_to = 1'b0;
        m_held++;
      end
    end
    #1;
    chk("gnt",     32'(gnt),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("gntval",  32'(gntval),  32'(m_owner >= 0));
    chk("gntid",   32'(gntid),   32'(m_id));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("vote_prior", 32'(vote_prior), 32'(m_prior));
  endtask

  initial begin
    logic [7:0] q, m;
    logic       d, r;
    rst = 1'b1; reqin = '0; gntdone = 1'b0; reqmsk = '0;

    // Reset then idle
    step(1, 8'h00, 0, 8'h00);
    step(1, 8'h00, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 8'h00);

    // Alternating grants between requesters 2 and 5, done two cycles after grant
    for (int i = 0; i < 16; i++) step(0, 8'h24, (m_owner >= 0 && m_held == 1), 8'h00);
    step(0, 8'h00, 0, 8'h00);

    // Lone requester 7 held to timeout, priority wraps to 0
    for (int i = 0; i < 8; i++) step(0, 8'h80, 0, 8'h00);
    step(0, 8'h00, 0, 8'h00);

    // Implicit release by request drop
    step(0, 8'h01, 0, 8'h00);
    step(0, 8'h01, 0, 8'h00);
    step(0, 8'h00, 0, 8'h00);

    // Reset during a grant to requester 6
    step(0, 8'h40, 0, 8'h00);
    step(0, 8'h40, 0, 8'h00);
    step(1, 8'h40, 0, 8'h00);
    step(0, 8'h00, 0, 8'h00);

`ifdef AF4_IPOH_GNT8_MASK_EN
    // Masked requester excluded, mask change releases the owner
    step(0, 8'h03, 0, 8'h01);
    step(0, 8'h03, 0, 8'h01);
    step(0, 8'h03, 0, 8'h02);
    step(0, 8'h03, 0, 8'h02);
    step(0, 8'h00, 0, 8'h00);
`endif

    // Randomized traffic
    q = 8'h00; m = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) q = 8'($urandom);
      d = ($urandom_range(0, 3) == 0);
`ifdef AF4_IPOH_GNT8_MASK_EN
      if ($urandom_range(0, 7) == 0) m = 8'($urandom);
`endif
      step(r, q, d, m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
